// File: rtl/rx_pkg.sv
// Shared definitions for the 8-bit UART receive path (FSM encoding, parity constants).
// Also imported by the transmit side for the parity-mode constants.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BITS  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } rx_state_e;

  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 0;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_baud_timer.sv
// Bit-period timer for the UART receiver: flags the half-bit point and the last tick of a bit.
// With RX_MAJORITY_VOTE_EN the clear value is 1, because the receiver restarts one cycle late.
module rx_baud_timer #(
  parameter int BIT_TICKS  = 5208,
  parameter int HALF_TICKS = 2604
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_done,
  output logic full_done
);

  localparam int W = $clog2(BIT_TICKS + 1);

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [W-1:0] CLR_VAL = W'(1);
`else
  localparam logic [W-1:0] CLR_VAL = W'(0);
`endif

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= CLR_VAL;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // full_done marks the final tick so that consecutive samples are exactly BIT_TICKS apart
  assign half_done = (cnt_q == W'(HALF_TICKS));
  assign full_done = (cnt_q == W'(BIT_TICKS - 1));

endmodule

// File: rtl/rx.sv
// UART receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop; strobes each completed frame.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote around every sample point.
module rx
  import rx_pkg::*;
#(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD_RATE   = 19200,
  parameter int PARITY_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       busy,
  output logic       parity_error,
  output logic       framing_error
);

  localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;

  logic [1:0] sync_q;
  logic [1:0] valid_q;
  logic       rx_s;
  logic       rx_prev_q;
  logic       fall_edge;
  logic       half_done;
  logic       full_done;
  logic       half_tick;
  logic       full_tick;
  logic       sample;
  logic       timer_clr;
  logic       exp_par;

  rx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       par_bit_q, par_bit_d;
  logic [7:0] dout_q, dout_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       strobe_q, strobe_d;

  assign rx_s = sync_q[1];

  // rx_prev only follows rx_s once the synchronizer holds real line data, so a line
  // held low through reset release never looks like a falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      valid_q   <= 2'b00;
      rx_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      valid_q   <= {valid_q[0], 1'b1};
      rx_prev_q <= valid_q[1] & rx_s;
    end
  end

  assign fall_edge = rx_prev_q & ~rx_s;

  rx_baud_timer #(
    .BIT_TICKS (BIT_TICKS),
    .HALF_TICKS(HALF_TICKS)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .half_done(half_done),
    .full_done(full_done)
  );

`ifdef RX_MAJORITY_VOTE_EN
  logic rx_d1_q, rx_d2_q, half_q, full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_d1_q <= 1'b1;
      rx_d2_q <= 1'b1;
      half_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      rx_d1_q <= rx_s;
      rx_d2_q <= rx_d1_q;
      half_q  <= half_done;
      full_q  <= full_done;
    end
  end

  assign half_tick = half_q;
  assign full_tick = full_q;
  assign sample    = maj3(rx_s, rx_d1_q, rx_d2_q);
`else
  assign half_tick = half_done;
  assign full_tick = full_done;
  assign sample    = rx_s;
`endif

  assign exp_par = (PARITY_MODE == PARITY_ODD) ? ~^shift_q : ^shift_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_bit_d = par_bit_q;
    dout_d    = dout_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    strobe_d  = 1'b0;
    timer_clr = 1'b0;
    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (fall_edge) state_d = START;
      end
      START: begin
        if (half_tick) begin
          if (sample) begin
            state_d = IDLE;
          end else begin
            timer_clr = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = BITS;
          end
        end
      end
      BITS: begin
        if (full_tick) begin
          shift_d   = {sample, shift_q[7:1]};
          timer_clr = 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PAR;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PAR: begin
        if (full_tick) begin
          par_bit_d = sample;
          timer_clr = 1'b1;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (full_tick) begin
          dout_d    = shift_q;
          perr_d    = (par_bit_q != exp_par);
          ferr_d    = ~sample;
          strobe_d  = 1'b1;
          timer_clr = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // wait out a held-low line so a break cannot retrigger a frame
        timer_clr = 1'b1;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        timer_clr = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      par_bit_q <= 1'b0;
      dout_q    <= 8'h00;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_bit_q <= par_bit_d;
      dout_q    <= dout_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      strobe_q  <= strobe_d;
    end
  end

  assign dout          = dout_q;
  assign data_strobe   = strobe_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q == START) || (state_q == BITS) ||
                         (state_q == PAR)   || (state_q == STOP);

endmodule

// File: tb/tb_rx.sv
// Directed bench for rx: an odd-parity and an even-parity receiver, each on its own line.
// Bit period scaled to 100 clocks so the whole run stays short.
module tb_rx;

  localparam int CLK_FREQ = 1920000;
  localparam int BAUD     = 19200;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;
  localparam int LAT_NOM  = 2 + 1 + HALF + 10 * BIT + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line_o = 1'b1;
  logic       line_e = 1'b1;
  logic [7:0] dout_o, dout_e;
  logic       strb_o, strb_e, busy_o, busy_e, perr_o, perr_e, ferr_o, ferr_e;

  rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_MODE(1)) u_dut_odd (
    .clk(clk), .rst(rst), .rx_in(line_o), .dout(dout_o), .data_strobe(strb_o),
    .busy(busy_o), .parity_error(perr_o), .framing_error(ferr_o)
  );

  rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY_MODE(0)) u_dut_even (
    .clk(clk), .rst(rst), .rx_in(line_e), .dout(dout_e), .data_strobe(strb_e),
    .busy(busy_e), .parity_error(perr_e), .framing_error(ferr_e)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_o = 0;
  int         n_e = 0;
  bit         busy_seen_o = 1'b0;
  int         st_cyc_o[$];
  logic [7:0] st_byte_o[$];

  always @(posedge clk) begin
    #1;
    if (strb_o) begin
      n_o++;
      st_cyc_o.push_back(cyc);
      st_byte_o.push_back(dout_o);
    end
    if (strb_e) n_e++;
    if (busy_o) busy_seen_o = 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic send_bit(input bit which, input logic b);
    if (which) line_e = b;
    else line_o = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input logic p, input logic s);
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(which, d[i]);
    send_bit(which, p);
    send_bit(which, s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, t0, lat, gap, sz;
    logic [7:0] b_first, b_second;

    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_dout", 32'(dout_o), 32'h00);
    chk("rst_strobe", 32'(strb_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_perr", 32'(perr_o), 32'h0);
    chk("rst_ferr", 32'(ferr_o), 32'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // odd mode, 0xA5 with correct parity
    busy_seen_o = 1'b0;
    n0 = n_o;
    t0 = cyc;
    send_frame(1'b0, 8'hA5, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("a5_strobes", 32'(n_o - n0), 32'd1);
    chk("a5_dout", 32'(dout_o), 32'hA5);
    chk("a5_perr", 32'(perr_o), 32'h0);
    chk("a5_ferr", 32'(ferr_o), 32'h0);
    chk("a5_busy_seen", 32'(busy_seen_o), 32'h1);
    chk("a5_busy_after", 32'(busy_o), 32'h0);
    lat = (st_cyc_o.size() > 0) ? st_cyc_o[$] - t0 : -1000;
    chk("a5_latency_in_window", 32'(lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2), 32'h1);

    // even mode, 0x3C with wrong parity bit, then good 0x01 clears the flag
    n0 = n_e;
    send_frame(1'b1, 8'h3C, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("3c_strobes", 32'(n_e - n0), 32'd1);
    chk("3c_dout", 32'(dout_e), 32'h3C);
    chk("3c_perr", 32'(perr_e), 32'h1);
    chk("3c_ferr", 32'(ferr_e), 32'h0);
    send_frame(1'b1, 8'h01, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("01_strobes", 32'(n_e - n0), 32'd2);
    chk("01_dout", 32'(dout_e), 32'h01);
    chk("01_perr", 32'(perr_e), 32'h0);

    // short low glitch: false start
    busy_seen_o = 1'b0;
    n0 = n_o;
    line_o = 1'b0;
    repeat (20) @(negedge clk);
    line_o = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("glitch_strobes", 32'(n_o - n0), 32'd0);
    chk("glitch_busy_seen", 32'(busy_seen_o), 32'h1);
    chk("glitch_busy_after", 32'(busy_o), 32'h0);
    chk("glitch_dout_kept", 32'(dout_o), 32'hA5);

    // 0x55 with stop bit 0, line held low afterwards
    n0 = n_o;
    send_frame(1'b0, 8'h55, 1'b1, 1'b0);
    busy_seen_o = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    chk("brk_strobes", 32'(n_o - n0), 32'd1);
    chk("brk_dout", 32'(dout_o), 32'h55);
    chk("brk_ferr", 32'(ferr_o), 32'h1);
    chk("brk_perr", 32'(perr_o), 32'h0);
    chk("brk_busy_held_low", 32'(busy_seen_o), 32'h0);
    line_o = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("brk_no_second_frame", 32'(n_o - n0), 32'd1);

    // reset in the middle of data bit 4, line held low through release
    n0 = n_o;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    line_o = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("abort_busy_pre", 32'(busy_o), 32'h1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_dout", 32'(dout_o), 32'h00);
    chk("abort_ferr", 32'(ferr_o), 32'h0);
    chk("abort_perr", 32'(perr_o), 32'h0);
    chk("abort_busy", 32'(busy_o), 32'h0);
    chk("abort_strobe", 32'(strb_o), 32'h0);
    rst = 1'b1;
    busy_seen_o = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    chk("abort_low_no_start", 32'(busy_seen_o), 32'h0);
    chk("abort_no_strobe", 32'(n_o - n0), 32'd0);
    line_o = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    // back-to-back 0x00 then 0xFF, no idle gap
    n0 = n_o;
    send_frame(1'b0, 8'h00, 1'b1, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("b2b_strobes", 32'(n_o - n0), 32'd2);
    sz = st_cyc_o.size();
    gap = (sz >= 2) ? st_cyc_o[sz-1] - st_cyc_o[sz-2] : -1000;
    b_first  = (sz >= 2) ? st_byte_o[sz-2] : 8'hEE;
    b_second = (sz >= 2) ? st_byte_o[sz-1] : 8'hEE;
    chk("b2b_first_byte", 32'(b_first), 32'h00);
    chk("b2b_second_byte", 32'(b_second), 32'hFF);
    chk("b2b_gap_in_window", 32'(gap >= 11 * BIT - 2 && gap <= 11 * BIT + 2), 32'h1);
    chk("b2b_perr", 32'(perr_o), 32'h0);
    chk("b2b_ferr", 32'(ferr_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx.md
Name: rx

Overview:
- Parameterized asynchronous serial receiver; the receive end of the team's 8-bit UART link.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1); idle line is 1.
- Deserializes the frame, checks parity and stop bit, and presents the byte with a one-cycle strobe to downstream logic.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 19200, serial bit rate in bits/s.
- PARITY_MODE, 1, 1 = odd parity, 0 = even parity.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- rx_in  input  1  serial line, asynchronous to clk.
- dout  output  8  last received byte.
- data_strobe  output  1  one-cycle pulse when dout, parity_error and framing_error update.
- busy  output  1  high from start-bit detection until the frame completes.
- parity_error  output  1  parity mismatch on the last frame.
- framing_error  output  1  stop bit sampled 0 on the last frame.

Behaviour:
- Constants: BIT_TICKS = CLK_FREQ/BAUD_RATE; HALF_TICKS = BIT_TICKS/2, integer division. Timer width is $clog2(BIT_TICKS+1).
- rx_in passes through a 2-flop synchronizer, reset value 1, to give rx_s. rx_prev is the registered rx_s, reset value 0.
- Falling edge = rx_prev==1 && rx_s==0. Because rx_prev resets to 0, a line held low through reset release cannot start a frame until it has been seen high.
- Reset values: dout=0, data_strobe=0, busy=0, parity_error=0, framing_error=0; state=IDLE; timer=0; bit counter=0.
- Asserting rst mid-frame aborts the frame immediately: no strobe, and the error flags clear.
- IDLE:
  - busy=0, timer held clear.
  - On a falling edge go to START and clear the timer.
- START:
  - busy=1.
  - When the timer reaches HALF_TICKS, sample rx_s.
  - Sample 1: false start; go to IDLE with no strobe and outputs unchanged.
  - Sample 0: clear the timer and bit counter, go to BITS.
- BITS:
  - At each timer==BIT_TICKS (mid-bit), shift rx_s into bit[7] of the shift register; the register shifts right, so the LSB arrives first. Then restart the timer.
  - After the 8th sample (counter==7), go to PAR.
- PAR:
  - Sample at timer==BIT_TICKS into par_bit.
  - Expected parity: odd mode ~^data, even mode ^data.
- STOP:
  - Sample at timer==BIT_TICKS.
  - The next cycle: dout<=shift register; parity_error<=(par_bit != expected); framing_error<=~sample; data_strobe=1 for exactly one cycle.
  - Go to DONE.
- DONE:
  - busy=0.
  - If rx_s==0 (break or framing error), stay until rx_s==1, then go to IDLE.
  - Otherwise go to IDLE the following cycle.
  - This prevents a held-low line from retriggering.
- The strobe fires on every completed frame, including frames with errors. Error flags and dout hold until the next strobe.
- Latency: data_strobe rises 2 (synchronizer) + 1 (edge) + HALF_TICKS + 10*BIT_TICKS + ~2 cycles after the rx_in falling edge, ±2 cycles.
- A falling edge during BITS, PAR or STOP is ignored: no resynchronization within a frame.
- Back-to-back frames: a start bit arriving immediately after the stop bit is accepted, since DONE exits before mid-start.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro: RX_MAJORITY_VOTE_EN.
- Defined: each sample point (start, data, parity and stop) uses a 2-of-3 majority of rx_s at timer values T-1, T and T+1 around the nominal sample tick T. The decision is taken at T+1 and timing references stay at T, so there is no cumulative drift.
- Undefined: single sample at T, exactly as described above.

Decomposition:
- Package rx_pkg: state enum {IDLE, START, BITS, PAR, STOP, DONE}, and PARITY_ODD=1 / PARITY_EVEN=0 constants. The team's tx can import the same constants.
- One sub-module, rx_baud_timer: BIT_TICKS and HALF_TICKS params; inputs clk, rst, clr; outputs half_done, full_done.
- The FSM and datapath stay in rx.

Test Plan (all at CLK_FREQ=100e6, BAUD_RATE=19200, so BIT_TICKS=5208):
- Odd mode, frame for 0xA5 with parity bit 1 and stop 1 -> one data_strobe pulse, dout=0xA5, parity_error=0, framing_error=0; busy low after stop.
- Even mode, frame for 0x3C with parity bit forced 1 (wrong) -> dout=0x3C, parity_error=1; the next good frame 0x01 clears it to 0.
- Low glitch of 1000 cycles on an idle line -> returns to IDLE, no strobe, busy pulses then drops, dout unchanged.
- Frame 0x55 with stop bit 0 and line held low 3 bit times -> strobe once, framing_error=1, no second frame until the line returns high.
- Two back-to-back frames 0x00 then 0xFF with no idle gap -> two strobes ~11*5208 cycles apart with the correct bytes.
- rst pulled low mid-data-bit 4 with rx_in held low through release -> all outputs 0; no frame detected until the line goes high then low.
